// File: rtl/grid_path_planner.sv
// Greedy Manhattan walker on a 16x16 grid: emits X moves of up to 3 cells, then Y moves,
// over a valid/ready channel, and pulses done when the target is reached.
module grid_path_planner (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] start_x,
  input  logic [3:0] start_y,
  input  logic [3:0] target_x,
  input  logic [3:0] target_y,
  output logic       move_valid,
  input  logic       move_ready,
  output logic [1:0] dir,
  output logic [1:0] dis,
  output logic [3:0] cur_x,
  output logic [3:0] cur_y,
  output logic [3:0] move_count,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state_o
);

  // Handshake: a move transfers on a rising edge where move_valid && move_ready.
  // While move_valid is high and move_ready is low, dir/dis stay stable because
  // they depend only on registered state that does not change without a transfer.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_X = 2'd1,
    MOVE_Y = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] tgt_x_q, tgt_x_d;
  logic [3:0] tgt_y_q, tgt_y_d;
  logic [3:0] cur_x_q, cur_x_d;
  logic [3:0] cur_y_q, cur_y_d;
  logic [3:0] count_q, count_d;

  logic       x_fwd, y_fwd;
  logic [3:0] x_rem, y_rem;
  logic [1:0] x_step, y_step;
  logic       fire;

  always_comb begin
    x_fwd  = (tgt_x_q > cur_x_q);
    y_fwd  = (tgt_y_q > cur_y_q);
    x_rem  = x_fwd ? (tgt_x_q - cur_x_q) : (cur_x_q - tgt_x_q);
    y_rem  = y_fwd ? (tgt_y_q - cur_y_q) : (cur_y_q - tgt_y_q);
    x_step = (x_rem > 4'd3) ? 2'd3 : x_rem[1:0];
    y_step = (y_rem > 4'd3) ? 2'd3 : y_rem[1:0];
  end

  always_comb begin
    move_valid = 1'b0;
    dir        = 2'b00;
    dis        = 2'b00;
    case (state_q)
      MOVE_X: begin
        move_valid = 1'b1;
        dir        = {1'b0, ~x_fwd};
        dis        = x_step;
      end
      MOVE_Y: begin
        move_valid = 1'b1;
        dir        = {1'b1, ~y_fwd};
        dis        = y_step;
      end
      default: ;
    endcase
  end

  assign fire = move_valid & move_ready;

  always_comb begin
    state_d = state_q;
    tgt_x_d = tgt_x_q;
    tgt_y_d = tgt_y_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          tgt_x_d = target_x;
          tgt_y_d = target_y;
          cur_x_d = start_x;
          cur_y_d = start_y;
          count_d = 4'd0;
          if (target_x != start_x)      state_d = MOVE_X;
          else if (target_y != start_y) state_d = MOVE_Y;
          else                          state_d = DONE;
        end
      end
      MOVE_X: begin
        if (fire) begin
          cur_x_d = x_fwd ? (cur_x_q + {2'b00, x_step}) : (cur_x_q - {2'b00, x_step});
          count_d = count_q + 4'd1;
          // The step equals the remaining distance only on the final X move.
          if (x_rem == {2'b00, x_step}) begin
            if (tgt_y_q != cur_y_q) state_d = MOVE_Y;
            else                    state_d = DONE;
          end
        end
      end
      MOVE_Y: begin
        if (fire) begin
          cur_y_d = y_fwd ? (cur_y_q + {2'b00, y_step}) : (cur_y_q - {2'b00, y_step});
          count_d = count_q + 4'd1;
          if (y_rem == {2'b00, y_step}) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tgt_x_q <= 4'd0;
      tgt_y_q <= 4'd0;
      cur_x_q <= 4'd0;
      cur_y_q <= 4'd0;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      tgt_x_q <= tgt_x_d;
      tgt_y_q <= tgt_y_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      count_q <= count_d;
    end
  end

  assign cur_x       = cur_x_q;
  assign cur_y       = cur_y_q;
  assign move_count  = count_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign dbg_state_o = state_q;

endmodule

// File: doc/grid_path_planner.md
GRID_PATH_PLANNER -- requirements
Module: grid_path_planner

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start, input, 1, request to plan a walk; sampled only in IDLE.
REQ-004 SHALL have ports start_x and start_y, input, 4 each, unsigned origin coordinates on the 16x16 grid.
REQ-005 SHALL have ports target_x and target_y, input, 4 each, unsigned destination coordinates.
REQ-006 SHALL have port move_valid, output, 1, high while a move is offered.
REQ-007 SHALL have port move_ready, input, 1, consumer accepts the move when high together with move_valid.
REQ-008 SHALL have port dir, output, 2, move direction: 00 = +X, 01 = -X, 10 = +Y, 11 = -Y.
REQ-009 SHALL have port dis, output, 2, step magnitude 1..3; 00 is never emitted while move_valid is high.
REQ-010 SHALL have ports cur_x and cur_y, output, 4 each, position after all moves accepted so far.
REQ-011 SHALL have port move_count, output, 4, number of moves accepted in the current walk.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 SHALL have port done, output, 1, one-cycle pulse when the walk completes.

Function
REQ-014 SHALL implement four states: IDLE, MOVE_X, MOVE_Y, DONE.
REQ-015 IDLE with start=1 SHALL latch start and target, load cur_x/cur_y from start_x/start_y, and clear move_count.
REQ-016 From IDLE with start=1, the next state SHALL be MOVE_X if target_x != start_x; else MOVE_Y if target_y != start_y; else DONE.
REQ-017 In MOVE_X, move_valid SHALL be 1.
REQ-018 In MOVE_X, dir SHALL be 00 when target_x > cur_x and 01 otherwise.
REQ-019 In MOVE_X, dis SHALL be min(3, |target_x - cur_x|).
REQ-020 MOVE_Y SHALL behave like MOVE_X using the Y coordinates, with dir 10 or 11.
REQ-021 dir, dis and move_valid SHALL be driven from registered state only and SHALL stay stable while move_valid=1 and move_ready=0.
REQ-022 A handshake (move_valid and move_ready both 1 on a clock edge) SHALL, on that edge, add dis to or subtract dis from cur_x or cur_y per dir and increment move_count.
REQ-023 A handshake on the last X move (remaining X distance becomes 0) SHALL go to MOVE_Y if target_y != cur_y, else to DONE.
REQ-024 A handshake on the last Y move SHALL go to DONE.
REQ-025 All coordinate arithmetic SHALL be 4-bit; a greedy step never passes the target, so no wrap-around occurs.
REQ-026 Moves SHALL follow a fixed order: all X moves first, then all Y moves.
REQ-027 DONE SHALL assert done=1 and busy=1 for exactly one cycle, then return to IDLE.
REQ-028 move_count and cur_x/cur_y SHALL hold their final values in IDLE until the next accepted start.
REQ-029 start while busy=1 SHALL be ignored, and the latched target SHALL be unchanged.
REQ-030 start asserted in the DONE cycle SHALL be ignored; a new walk starts only from IDLE.
REQ-031 move_ready while move_valid=0 SHALL have no effect.
REQ-032 The maximum walk SHALL be 10 moves (5 X plus 5 Y); move_count SHALL never exceed 10.

Reset
REQ-033 reset=1 on a clock edge SHALL force IDLE, move_valid=0, done=0, busy=0, dir=00, dis=00, cur_x=0, cur_y=0, move_count=0, regardless of state.
REQ-034 reset SHALL take priority over start and over any move handshake in the same cycle.
REQ-035 reset mid-walk SHALL abandon the walk; no done pulse SHALL be produced for it.

Verification
REQ-036 Scenario: start (0,0) to (7,2), move_ready held 1 -> moves +X3, +X3, +X1, +Y2 on consecutive cycles; done pulses; cur=(7,2); move_count=4.
REQ-037 Scenario: start (9,9) to (9,9) -> move_valid never rises; done pulses on the cycle after start; move_count=0.
REQ-038 Scenario: start (15,0) to (0,15) -> five -X3 moves then five +Y3 moves; move_count=10; cur=(0,15).
REQ-039 Scenario: start (4,4) to (2,6) with move_ready low for 3 cycles -> -X2 held stable for all 3 cycles, then accepted; next move is +Y2.
REQ-040 Scenario: reset asserted after the second accepted move of (0,0) to (12,12) -> next cycle IDLE, all outputs 0, no done pulse.
REQ-041 Scenario: second start to (1,1) issued mid-walk of (0,0) to (6,0) -> ignored; walk ends at (6,0).
